fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side responder for the team's synchronous FIFO. It drains the FIFO through its read port (rd_en, registered rd_data, empty) and presents the words on a valid/ready stream for downstream consumers.
- Hides the FIFO's 1-cycle read latency with a 2-entry prefetch buffer, so it sustains 1 word/cycle with m_ready high.
- Sits between the FIFO DUT and the output interface watched by the output monitor.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and the stream data.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- drain_en  in  1  enables issuing new FIFO reads.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe, one word per cycle asserted.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- m_valid  out  1  stream word available.
- m_data  out  DATA_WIDTH  stream data.
- m_ready  in  1  consumer accepts the word when m_valid && m_ready.
- rd_count  out  CNT_WIDTH  count of words accepted on the stream.
- busy  out  1  high when buffer occupancy is greater than 0 or a read is in flight.

Behaviour:
- Reset, async on rst_n low:
  - fifo_rd_en=0, m_valid=0, m_data=0, rd_count=0, busy=0.
  - Occupancy cleared to 0 and in_flight cleared to 0.
  - Any read in flight is discarded; data returning after reset release is ignored.
- Buffer and state machine:
  - 2-entry in-order buffer; occupancy FSM with states EMPTY(0), ONE(1), TWO(2).
  - in_flight register = fifo_rd_en delayed by one cycle.
- Read issue:
  - fifo_rd_en = drain_en && !fifo_empty && (occupancy + in_flight − pop) < 2, where pop = m_valid && m_ready.
  - fifo_rd_en is combinational and is never asserted while fifo_empty=1.
- Capture: when in_flight=1, fifo_rd_data is written into the buffer tail in that cycle.
- Stream output:
  - m_valid = (occupancy != 0); m_data = buffer head.
  - m_valid and m_data are registered outputs.
  - While m_valid && !m_ready, m_valid stays 1 and m_data stays stable.
- FSM transitions, with push=in_flight:
  - EMPTY: push → ONE.
  - ONE: push && !pop → TWO; pop && !push → EMPTY; push && pop → ONE (head advances to the new word).
  - TWO: pop → ONE. push is impossible in TWO by the issue rule; an assertion checks this.
- Latency:
  - First word: fifo_rd_en in cycle N, m_valid=1 in cycle N+2.
  - Steady state: 1 word/cycle with m_ready=1 and the FIFO non-empty.
- drain_en:
  - Deassertion stops new reads only.
  - An in-flight word is still captured; buffered words are still delivered.
- rd_count increments by 1 on each pop and wraps modulo 2^CNT_WIDTH.
- Ordering: words leave in exactly FIFO order; no loss or duplication under any m_ready pattern.

Decomposition:
- Package fifo_rd_pkg holds:
  - occ_state_e enum {EMPTY, ONE, TWO}.
  - localparam BUF_DEPTH=2.
- Sub-module fifo_rd_skid, a 2-entry buffer with push/pop, head data and occupancy. fifo_rd_stream holds the issue logic, in_flight and rd_count.

Test Plan:
- Reset, then push 0x11,0x22,0x33 into the FIFO with drain_en=1 and m_ready=1 → first fifo_rd_en at N, m_valid at N+2, data 0x11,0x22,0x33 on consecutive cycles, rd_count=3, busy=0 after.
- FIFO holds 0x01..0x08, m_ready=0 → exactly 2 reads issued, m_data=0x01 held stable; on m_ready=1, 0x01..0x08 arrive in order at 1/cycle.
- m_ready toggling 1,0,1,0 over 10 words 0xA0..0xA9 → all 10 received in order, none repeated, rd_count=10.
- drain_en dropped the cycle after a fifo_rd_en → that word is still delivered, no further fifo_rd_en, remaining FIFO words untouched.
- FIFO empty throughout, drain_en=1 → fifo_rd_en never asserted, m_valid=0.
- rst_n pulsed low with occupancy=2 and a read in flight → all outputs 0 immediately; after release no stale word appears, and the next word delivered is the next one read from the FIFO.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side stream responder.
// Occupancy encoding doubles as the entry count of the prefetch buffer.
package fifo_rd_pkg;

   localparam int BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_state_e;

   function automatic logic [1:0] occ_count(input occ_state_e s);
      return s;
   endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order prefetch buffer: head feeds the stream, tail absorbs
// the word that was already requested from the FIFO when the head stalls.
import fifo_rd_pkg::*;

module fifo_rd_skid #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output occ_state_e            state
);

   logic [DATA_WIDTH-1:0] tail_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         head_data <= '0;
         tail_data <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  head_data <= push_data;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  tail_data <= push_data;
                  state     <= TWO;
               end else if (pop && !push) begin
                  state <= EMPTY;
               end else if (push && pop) begin
                  head_data <= push_data;
               end
            end
            TWO: begin
               // The issue rule keeps a push from ever landing while full.
               if (pop) begin
                  head_data <= tail_data;
                  state     <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
      !(state == TWO && push));

   a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
      !(state == EMPTY && pop));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the synchronous FIFO read port onto a valid/ready stream, using a
// 2-entry prefetch so the 1-cycle read latency never throttles throughput.
import fifo_rd_pkg::*;

module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  drain_en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  busy
);

   occ_state_e state;
   logic       in_flight;
   logic       pop;
   logic [1:0] occupancy;
   logic [2:0] demand;

   assign occupancy = occ_count(state);
   assign pop       = m_valid && m_ready;

   // Slots already claimed after this cycle's pop; pop implies occupancy >= 1.
   assign demand = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, pop};

   // Gated by rst_n so no read is requested while reset is held.
   assign fifo_rd_en = rst_n && drain_en && !fifo_empty && (demand < 3'(BUF_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_flight <= 1'b0;
         rd_count  <= '0;
      end else begin
         in_flight <= fifo_rd_en;
         if (pop) rd_count <= rd_count + 1'b1;
      end
   end

   fifo_rd_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_flight),
      .push_data (fifo_rd_data),
      .pop       (pop),
      .head_data (m_data),
      .state     (state)
   );

   assign m_valid = (state != EMPTY);
   assign busy    = m_valid || in_flight;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO, scoreboard of pushed words,
// hand sequences for latency/stall/drain/reset, table rows and random traffic.
module tb_fifo_rd_stream;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          drain_en = 1'b0;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b0;
   logic [CW-1:0] rd_count;
   logic          busy;

   fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .drain_en     (drain_en),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .rd_count     (rd_count),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // FIFO model with registered read data
   logic [7:0] mem [256];
   int wr_idx = 0;
   int rd_idx = 0;
   int issued = 0;

   assign fifo_empty = (wr_idx == rd_idx);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_idx % 256];
         rd_idx       <= rd_idx + 1;
         issued       <= issued + 1;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   int delivered = 0;
   int discarded = 0;
   int count_model = 0;
   logic [7:0] exp_q [$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] v);
      mem[wr_idx % 256] = v;
      wr_idx++;
      exp_q.push_back(v);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            count_model = 0;
            prev_stall  = 1'b0;
         end else begin
            check("rd_count", 32'(rd_count), 32'(count_model % (1 << CW)));
            if (fifo_empty) check("rd_en_while_empty", 32'(fifo_rd_en), 0);
            check("outstanding_le_2", 32'((issued - delivered - discarded) <= 2), 1);
            if (prev_stall) begin
               check("stall_valid", 32'(m_valid), 1);
               check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) check("word_expected", 32'(exp_q.size()), 1);
               else check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
               delivered++;
               count_model++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
         end
      end
   endtask

   typedef struct {
      logic [7:0] base;
      int         n;
      int         rmode;   // 0 always ready, 1 toggle, 2 random
      logic       drain;
      int         exp_deliv;
      int         exp_left;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0, d0, n_drop;
      bit found;

      vecs[0] = '{8'hA0, 10, 1, 1'b1, 10, 0};
      vecs[1] = '{8'h40, 5,  0, 1'b0, 0,  5};
      vecs[2] = '{8'h50, 2,  0, 1'b1, 7,  0};
      vecs[3] = '{8'h60, 6,  2, 1'b1, 6,  0};

      fork monitor(); join_none

      // reset state
      #1 rst_n = 1'b0;
      #2;
      check("rst_rd_en", 32'(fifo_rd_en), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_rd_count", 32'(rd_count), 0);
      check("rst_busy", 32'(busy), 0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

      // first-word latency and back-to-back delivery
      drain_en = 1'b1; m_ready = 1'b1;
      step();
      push_word(8'h11); push_word(8'h22); push_word(8'h33);
      found = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (fifo_rd_en) begin found = 1; break; end
      end
      check("first_rd_en_seen", 32'(found), 1);
      @(negedge clk); check("lat_valid_n1", 32'(m_valid), 0);
      @(negedge clk); check("lat_valid_n2", 32'(m_valid), 1); check("lat_data_n2", 32'(m_data), 32'h11);
      @(negedge clk); check("lat_valid_n3", 32'(m_valid), 1); check("lat_data_n3", 32'(m_data), 32'h22);
      @(negedge clk); check("lat_valid_n4", 32'(m_valid), 1); check("lat_data_n4", 32'(m_data), 32'h33);
      @(negedge clk); check("lat_valid_n5", 32'(m_valid), 0);
      check("lat_rd_count", 32'(rd_count), 3);
      check("lat_busy", 32'(busy), 0);

      // consumer stall: only two words prefetched, head held
      step();
      m_ready = 1'b0; i0 = issued;
      for (int j = 1; j <= 8; j++) push_word(8'(j));
      repeat (10) step();
      check("stall_reads", 32'(issued - i0), 2);
      check("stall_m_valid", 32'(m_valid), 1);
      check("stall_head", 32'(m_data), 32'h01);
      m_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("stream_rate", 32'(m_valid), 1);
      end
      repeat (3) step();
      check("stall_done_valid", 32'(m_valid), 0);
      check("stall_done_busy", 32'(busy), 0);

      // table rows
      for (int r = 0; r < 4; r++) begin
         d0 = delivered;
         drain_en = vecs[r].drain;
         for (int j = 0; j < vecs[r].n; j++) push_word(8'(vecs[r].base + j));
         for (int c = 0; c < 40; c++) begin
            case (vecs[r].rmode)
               0: m_ready = 1'b1;
               1: m_ready = (c % 2 == 0);
               default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            step();
         end
         check("vec_delivered", 32'(delivered - d0), 32'(vecs[r].exp_deliv));
         check("vec_fifo_left", 32'(wr_idx - rd_idx), 32'(vecs[r].exp_left));
         check("vec_busy", 32'(busy), 0);
      end
      m_ready = 1'b1;

      // drain_en dropped right after one read
      drain_en = 1'b0; i0 = issued; d0 = delivered;
      push_word(8'hC0); push_word(8'hC1); push_word(8'hC2); push_word(8'hC3);
      repeat (3) step();
      check("drain_off_no_read", 32'(issued - i0), 0);
      drain_en = 1'b1;
      found = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (fifo_rd_en) begin found = 1; break; end
      end
      check("drain_rd_en_seen", 32'(found), 1);
      @(posedge clk); #1 drain_en = 1'b0;
      repeat (6) step();
      check("drain_one_read", 32'(issued - i0), 1);
      check("drain_one_word", 32'(delivered - d0), 1);
      check("drain_fifo_left", 32'(wr_idx - rd_idx), 3);
      check("drain_busy", 32'(busy), 0);
      drain_en = 1'b1;
      repeat (8) step();
      check("drain_rest_words", 32'(delivered - d0), 4);
      check("drain_rest_empty", 32'(wr_idx - rd_idx), 0);

      // FIFO empty throughout
      i0 = issued;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("empty_no_rd_en", 32'(fifo_rd_en), 0);
         check("empty_no_valid", 32'(m_valid), 0);
      end
      check("empty_no_reads", 32'(issued - i0), 0);

      // reset with a buffered word and a read in flight
      step();
      m_ready = 1'b0; drain_en = 1'b1;
      for (int j = 0; j < 6; j++) push_word(8'(8'hD0 + j));
      repeat (6) step();
      check("pre_rst_valid", 32'(m_valid), 1);
      m_ready = 1'b1;
      step();
      #1 rst_n = 1'b0;
      n_drop = issued - delivered - discarded;
      check("rst_outstanding", 32'(n_drop), 2);
      for (int j = 0; j < n_drop; j++) void'(exp_q.pop_front());
      discarded += n_drop;
      #1;
      check("arst_rd_en", 32'(fifo_rd_en), 0);
      check("arst_m_valid", 32'(m_valid), 0);
      check("arst_m_data", 32'(m_data), 0);
      check("arst_rd_count", 32'(rd_count), 0);
      check("arst_busy", 32'(busy), 0);
      d0 = delivered;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) step();
      check("post_rst_words", 32'(delivered - d0), 3);
      check("post_rst_empty", 32'(wr_idx - rd_idx), 0);
      check("post_rst_busy", 32'(busy), 0);

      // randomized traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0 && (wr_idx - rd_idx) < 200) push_word(8'($urandom));
         m_ready  = ($urandom_range(0, 3) != 0);
         drain_en = ($urandom_range(0, 7) != 0);
         step();
      end
      drain_en = 1'b1; m_ready = 1'b1;
      for (int g = 0; g < 500; g++) begin
         if (exp_q.size() == 0 && !busy) break;
         step();
      end
      check("rand_no_loss", 32'(exp_q.size()), 0);
      check("rand_fifo_empty", 32'(wr_idx - rd_idx), 0);
      check("rand_busy", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
